// File: rtl/router_pkg.sv
// Shared types for the output arbiter: FSM state encoding, port index type
// and the fixed number of input ports.
package router_pkg;

    localparam int NUM_PORTS = 16;

    typedef logic [3:0] port_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

endpackage : router_pkg

// File: rtl/rr_pick16.sv
// Combinational rotate-priority search: returns the first set bit of i_req
// found scanning upward from i_ptr, wrapping 15 -> 0.
module rr_pick16
    import router_pkg::*;
(
    input  logic [NUM_PORTS-1:0] i_req,
    input  port_idx_t            i_ptr,
    output logic                 o_found,
    output port_idx_t            o_idx
);

    port_idx_t w_pos;

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_pos   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            // 4-bit add wraps naturally from 15 back to 0
            w_pos = i_ptr + port_idx_t'(k);
            if (!o_found && i_req[w_pos]) begin
                o_found = 1'b1;
                o_idx   = w_pos;
            end
        end
    end

endmodule : rr_pick16

// File: rtl/output_arbiter.sv
// Round-robin arbiter for one router output: IDLE -> GRANT -> GAP FSM with a
// rotating pointer. Optional grant watchdog enabled by macro ARB_TIMEOUT_EN.
module output_arbiter
    import router_pkg::*;
#(
    parameter int NUM_REQ        = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_in,
    output logic [NUM_REQ-1:0] grant_out,
    output logic               busy_out,
    output port_idx_t          grant_id_out,
    output logic               timeout_out
);

    if (NUM_REQ != NUM_PORTS || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("output_arbiter: NUM_REQ must be 16 and TIMEOUT_CYCLES in 2..65535");
    end

    arb_state_t         r_state, w_state_nxt;
    port_idx_t          r_ptr, w_ptr_nxt;
    port_idx_t          r_owner, w_owner_nxt;
    logic               r_timeout, w_timeout_nxt;
    logic [NUM_REQ-1:0] w_eligible;
    logic               w_found;
    port_idx_t          w_pick;
    logic               w_owner_req;
    logic               w_expire;

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0]        r_cnt;
    logic [NUM_REQ-1:0] r_mask;

    assign w_eligible = req_in & ~r_mask;
    assign w_expire   = (r_cnt == CNT_LAST);

    // Counter is held at 0 outside GRANT so it starts from 0 on every new grant.
    // A blocked requester is released as soon as its request is seen low.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_mask <= '0;
        end else begin
            r_cnt  <= (r_state == GRANT) ? r_cnt + 16'd1 : 16'd0;
            r_mask <= (r_mask & req_in)
                    | (w_timeout_nxt ? (NUM_REQ'(1) << r_owner) : '0);
        end
    end
`else
    assign w_eligible = req_in;
    assign w_expire   = 1'b0;
`endif

    assign w_owner_req = req_in[r_owner];

    rr_pick16 u_pick (
        .i_req   (w_eligible),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_owner   <= w_owner_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_owner_nxt   = r_owner;
        w_timeout_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = GRANT;
                    w_owner_nxt = w_pick;
                end
            end
            GRANT: begin
                // Release takes priority; a watchdog revoke only applies to a live request
                if (!w_owner_req) begin
                    w_state_nxt = GAP;
                    w_ptr_nxt   = r_owner + 4'd1;
                end else if (w_expire) begin
                    w_state_nxt   = GAP;
                    w_ptr_nxt     = r_owner + 4'd1;
                    w_timeout_nxt = 1'b1;
                end
            end
            GAP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign busy_out     = (r_state == GRANT);
    assign grant_out    = busy_out ? (NUM_REQ'(1) << r_owner) : '0;
    assign grant_id_out = busy_out ? r_owner : '0;
    assign timeout_out  = r_timeout;

endmodule : output_arbiter

// File: tb/tb_output_arbiter.sv
// Directed self-checking bench for output_arbiter (vector table plus
// hand-written round-robin, reset and watchdog sequences).
module tb_output_arbiter;

    logic        clk;
    logic        reset;
    logic [15:0] req_in;
    logic [15:0] grant_out;
    logic        busy_out;
    logic [3:0]  grant_id_out;
    logic        timeout_out;

    int n_chk  = 0;
    int n_fail = 0;

    output_arbiter #(
        .NUM_REQ        (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_in       (req_in),
        .grant_out    (grant_out),
        .busy_out     (busy_out),
        .grant_id_out (grant_id_out),
        .timeout_out  (timeout_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_time_limit: simulation still running, required finish");
        $fatal(1, "time limit");
    end

    typedef struct {
        logic [15:0] req;
        logic        rst;
        logic [15:0] grant;
        logic        busy;
        logic [3:0]  id;
        logic        to;
    } vec_t;

    vec_t vecs[21];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [15:0] g, input logic b,
                           input logic [3:0] id, input logic to);
        chk({tag, ".grant"},   32'(grant_out),    32'(g));
        chk({tag, ".busy"},    32'(busy_out),     32'(b));
        chk({tag, ".id"},      32'(grant_id_out), 32'(id));
        chk({tag, ".timeout"}, 32'(timeout_out),  32'(to));
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        req_in = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int to_pulses;

        // req, rst, grant, busy, id, timeout (values after the edge)
        vecs[0]  = '{16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0,  1'b0};
        vecs[1]  = '{16'h0001, 1'b0, 16'h0001, 1'b1, 4'd0,  1'b0};
        vecs[2]  = '{16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0,  1'b0};
        vecs[3]  = '{16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0,  1'b0};
        vecs[4]  = '{16'h0020, 1'b0, 16'h0020, 1'b1, 4'd5,  1'b0};
        vecs[5]  = '{16'h0028, 1'b0, 16'h0020, 1'b1, 4'd5,  1'b0};
        vecs[6]  = '{16'h0020, 1'b0, 16'h0020, 1'b1, 4'd5,  1'b0};
        vecs[7]  = '{16'h0028, 1'b0, 16'h0020, 1'b1, 4'd5,  1'b0};
        vecs[8]  = '{16'h0020, 1'b0, 16'h0020, 1'b1, 4'd5,  1'b0};
        vecs[9]  = '{16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0,  1'b0};
        vecs[10] = '{16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0,  1'b0};
        vecs[11] = '{16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0,  1'b0};
        vecs[12] = '{16'h4000, 1'b0, 16'h4000, 1'b1, 4'd14, 1'b0};
        vecs[13] = '{16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0,  1'b0};
        vecs[14] = '{16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0,  1'b0};
        vecs[15] = '{16'h8001, 1'b0, 16'h8000, 1'b1, 4'd15, 1'b0};
        vecs[16] = '{16'h0001, 1'b0, 16'h0000, 1'b0, 4'd0,  1'b0};
        vecs[17] = '{16'h0001, 1'b0, 16'h0000, 1'b0, 4'd0,  1'b0};
        vecs[18] = '{16'h0001, 1'b0, 16'h0001, 1'b1, 4'd0,  1'b0};
        vecs[19] = '{16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0,  1'b0};
        vecs[20] = '{16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0,  1'b0};

        reset  = 1'b1;
        req_in = '0;
        step();
        step();
        chk_out("reset_state", 16'h0000, 1'b0, 4'd0, 1'b0);
        reset = 1'b0;

        // Single grant, owner-5 hold with req 3 pulsing, pointer wrap 15 -> 0
        for (int i = 0; i < 21; i++) begin
            req_in = vecs[i].req;
            reset  = vecs[i].rst;
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].grant, vecs[i].busy, vecs[i].id, vecs[i].to);
        end

        // All ports requesting: round-robin order 0..15 then 0, one GAP between grants
        do_reset();
        for (int k = 0; k < 17; k++) begin
            logic [3:0]  own;
            logic [15:0] oh;
            own = 4'(k % 16);
            oh  = 16'h0001 << own;
            req_in = 16'hFFFF;
            for (int c = 0; c < 3; c++) begin
                step();
                chk_out($sformatf("rr%0d_hold%0d", k, c), oh, 1'b1, own, 1'b0);
            end
            req_in = 16'hFFFF & ~oh;
            step();
            chk_out($sformatf("rr%0d_gap", k), 16'h0000, 1'b0, 4'd0, 1'b0);
            req_in = 16'hFFFF;
            step();
            chk_out($sformatf("rr%0d_idle", k), 16'h0000, 1'b0, 4'd0, 1'b0);
        end

        // Reset in the middle of a grant
        do_reset();
        req_in = 16'h0010;
        step();
        chk_out("rst_mid_grant", 16'h0010, 1'b1, 4'd4, 1'b0);
        reset = 1'b1;
        step();
        chk_out("rst_mid_drop", 16'h0000, 1'b0, 4'd0, 1'b0);
        reset  = 1'b0;
        req_in = 16'h0011;
        step();
        chk_out("rst_mid_restart", 16'h0001, 1'b1, 4'd0, 1'b0);
        req_in = 16'h0000;
        step();
        step();

        // Watchdog: port 2 holds forever, port 7 waiting
        do_reset();
        req_in = 16'h0084;
        step();
        chk_out("wd_grant2", 16'h0004, 1'b1, 4'd2, 1'b0);
`ifdef ARB_TIMEOUT_EN
        for (int c = 0; c < 7; c++) begin
            step();
            chk_out($sformatf("wd_hold%0d", c), 16'h0004, 1'b1, 4'd2, 1'b0);
        end
        step();
        chk_out("wd_revoke", 16'h0000, 1'b0, 4'd0, 1'b1);
        step();
        chk_out("wd_idle", 16'h0000, 1'b0, 4'd0, 1'b0);
        step();
        chk_out("wd_grant7", 16'h0080, 1'b1, 4'd7, 1'b0);
        req_in = 16'h0004;
        step();
        chk_out("wd_rel7", 16'h0000, 1'b0, 4'd0, 1'b0);
        to_pulses = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (timeout_out) to_pulses++;
            chk($sformatf("wd_blocked%0d.grant", c), 32'(grant_out), 32'h0);
        end
        chk("wd_no_repeat_pulse", 32'(to_pulses), 32'd0);
        req_in = 16'h0000;
        step();
        chk_out("wd_unblock", 16'h0000, 1'b0, 4'd0, 1'b0);
        req_in = 16'h0004;
        step();
        chk_out("wd_regrant2", 16'h0004, 1'b1, 4'd2, 1'b0);
`else
        to_pulses = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (timeout_out) to_pulses++;
            chk($sformatf("nowd_hold%0d.grant", c), 32'(grant_out), 32'h0004);
        end
        chk("nowd_no_pulse", 32'(to_pulses), 32'd0);
`endif
        req_in = 16'h0000;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_output_arbiter
